// File: rtl/tse_reset_sequencer.sv
//==============================================================================
// Module  : tse_reset_sequencer
// Brief   : Sequences TSE MAC system/TX/RX reset release after PLL lock.
//           Optional line-clock monitors: define TSE_RSTSEQ_CLKMON_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tse_reset_sequencer #(
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int CLKMON_WINDOW = 64
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    input  logic       err_clr,
    input  logic       tx_clk_tgl,
    input  logic       rx_clk_tgl,
    output logic       sys_rst_n,
    output logic       tx_rst_n,
    output logic       rx_rst_n,
    output logic       busy,
    output logic [2:0] state_o,
    output logic       lock_err,
    output logic [1:0] clk_err
);

    localparam int c_MAX_A   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int c_MAX_B   = (LOCK_TIMEOUT > CLKMON_WINDOW) ? LOCK_TIMEOUT : CLKMON_WINDOW;
    localparam int c_MAX     = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = ($clog2(c_MAX) < 1) ? 1 : $clog2(c_MAX);
    localparam int c_WIN_W   = $clog2(CLKMON_WINDOW + 1);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_HOLD  = 3'd1,
        S_LOCK  = 3'd2,
        S_SYS   = 3'd3,
        S_TX    = 3'd4,
        S_RX    = 3'd5,
        S_RUN   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_lock_s1;
    logic                 r_lock_s;
    logic                 w_reload;
    logic                 w_lock_to;
    logic                 w_tx_dead;
    logic                 w_rx_dead;
    logic                 w_active;
    logic                 w_abort;
    logic [1:0]           w_clk_set;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lock_s1 <= 1'b0;
            r_lock_s  <= 1'b0;
        end else begin
            r_lock_s1 <= pll_lock;
            r_lock_s  <= r_lock_s1;
        end
    end

`ifdef TSE_RSTSEQ_CLKMON_EN
    logic [1:0]         r_tx_sync;
    logic [1:0]         r_rx_sync;
    logic               r_tx_prev;
    logic               r_rx_prev;
    logic [c_WIN_W-1:0] r_tx_win;
    logic [c_WIN_W-1:0] r_rx_win;
    logic               w_tx_edge;
    logic               w_rx_edge;

    assign w_tx_edge = r_tx_sync[1] ^ r_tx_prev;
    assign w_rx_edge = r_rx_sync[1] ^ r_rx_prev;
    assign w_tx_dead = (r_tx_win == c_WIN_W'(CLKMON_WINDOW));
    assign w_rx_dead = (r_rx_win == c_WIN_W'(CLKMON_WINDOW));

    // Window counters restart on every detected toggle edge and stick at the limit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tx_sync <= '0;
            r_rx_sync <= '0;
            r_tx_prev <= 1'b0;
            r_rx_prev <= 1'b0;
            r_tx_win  <= '0;
            r_rx_win  <= '0;
        end else begin
            r_tx_sync <= {r_tx_sync[0], tx_clk_tgl};
            r_rx_sync <= {r_rx_sync[0], rx_clk_tgl};
            r_tx_prev <= r_tx_sync[1];
            r_rx_prev <= r_rx_sync[1];
            if (w_tx_edge)
                r_tx_win <= '0;
            else if (!w_tx_dead)
                r_tx_win <= r_tx_win + 1'b1;
            if (w_rx_edge)
                r_rx_win <= '0;
            else if (!w_rx_dead)
                r_rx_win <= r_rx_win + 1'b1;
        end
    end
`else
    logic w_unused_tgl;
    assign w_unused_tgl = tx_clk_tgl ^ rx_clk_tgl;
    assign w_tx_dead    = 1'b0;
    assign w_rx_dead    = 1'b0;
`endif

    assign w_active  = (r_state == S_SYS) || (r_state == S_TX) ||
                       (r_state == S_RX)  || (r_state == S_RUN);
    assign w_abort   = soft_rst_req || !r_lock_s || w_tx_dead || w_rx_dead;
    assign w_clk_set = {w_active & w_rx_dead, w_active & w_tx_dead};

    always_comb begin
        w_next    = r_state;
        w_reload  = 1'b0;
        w_lock_to = 1'b0;
        case (r_state)
            S_RESET: w_next = S_HOLD;
            S_HOLD: begin
                if (soft_rst_req)
                    w_reload = 1'b1;
                else if (r_cnt == c_CNT_W'(HOLD_CYCLES - 1))
                    w_next = S_LOCK;
            end
            S_LOCK: begin
                // A dead line clock only blocks the exit here; the timeout retries.
                if (soft_rst_req)
                    w_next = S_HOLD;
                else if (r_lock_s && !w_tx_dead && !w_rx_dead)
                    w_next = S_SYS;
                else if (r_cnt == c_CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_next    = S_HOLD;
                    w_lock_to = 1'b1;
                end
            end
            S_SYS: begin
                if (w_abort)
                    w_next = S_HOLD;
                else if (r_cnt == c_CNT_W'(STAGE_GAP - 1))
                    w_next = S_TX;
            end
            S_TX: begin
                if (w_abort)
                    w_next = S_HOLD;
                else if (r_cnt == c_CNT_W'(STAGE_GAP - 1))
                    w_next = S_RX;
            end
            S_RX:    w_next = w_abort ? S_HOLD : S_RUN;
            S_RUN:   w_next = w_abort ? S_HOLD : S_RUN;
            default: w_next = S_RESET;
        endcase
    end

    // Outputs decode the next state so they move on the same edge as state_o.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_RESET;
            r_cnt     <= '0;
            sys_rst_n <= 1'b0;
            tx_rst_n  <= 1'b0;
            rx_rst_n  <= 1'b0;
            busy      <= 1'b1;
            state_o   <= 3'd0;
            lock_err  <= 1'b0;
            clk_err   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_reload || (w_next != r_state))
                r_cnt <= '0;
            else if (r_cnt != {c_CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
            sys_rst_n <= (w_next == S_SYS) || (w_next == S_TX) ||
                         (w_next == S_RX)  || (w_next == S_RUN);
            tx_rst_n  <= (w_next == S_TX) || (w_next == S_RX) || (w_next == S_RUN);
            rx_rst_n  <= (w_next == S_RX) || (w_next == S_RUN);
            busy      <= (w_next != S_RUN);
            state_o   <= w_next;
            lock_err  <= w_lock_to | (lock_err & ~err_clr);
            clk_err   <= w_clk_set | (clk_err & ~{2{err_clr}});
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tse_reset_sequencer.sv
//==============================================================================
// Module  : tb_tse_reset_sequencer
// Brief   : Directed self-checking bench for tse_reset_sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_tse_reset_sequencer;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       err_clr;
    logic       tx_clk_tgl = 1'b0;
    logic       rx_clk_tgl = 1'b0;
    logic       sys_rst_n;
    logic       tx_rst_n;
    logic       rx_rst_n;
    logic       busy;
    logic [2:0] state_o;
    logic       lock_err;
    logic [1:0] clk_err;

    logic       tx_run = 1'b1;
    logic       rx_run = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;

    tse_reset_sequencer dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .err_clr      (err_clr),
        .tx_clk_tgl   (tx_clk_tgl),
        .rx_clk_tgl   (rx_clk_tgl),
        .sys_rst_n    (sys_rst_n),
        .tx_rst_n     (tx_rst_n),
        .rx_rst_n     (rx_rst_n),
        .busy         (busy),
        .state_o      (state_o),
        .lock_err     (lock_err),
        .clk_err      (clk_err)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        forever begin
            repeat (2) @(negedge HCLK);
            if (tx_run) tx_clk_tgl = ~tx_clk_tgl;
            if (rx_run) rx_clk_tgl = ~rx_clk_tgl;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Expected reset outputs and busy follow directly from the state table.
    task automatic chk_state(input string tag, input int st);
        logic [2:0] exp_rst;
        exp_rst = {(st >= 3 && st <= 6), (st >= 4 && st <= 6), (st >= 5 && st <= 6)};
        check_val({tag, "_state"}, 32'(state_o), 32'(st));
        check_val({tag, "_rstn"}, 32'({sys_rst_n, tx_rst_n, rx_rst_n}), 32'(exp_rst));
        check_val({tag, "_busy"}, 32'(busy), 32'(st != 6));
    endtask

    task automatic run_from_reset();
        int exp_st;
        for (int n = 1; n <= 27; n++) begin
            tick();
            exp_st = (n < 17) ? 1 : (n == 17) ? 2 : (n < 22) ? 3 :
                     (n < 26) ? 4 : (n == 26) ? 5 : 6;
            chk_state("seq", exp_st);
        end
    endtask

    // Called right after LOCK is entered with lock_s already high.
    task automatic release_seq(input string tag);
        tick(); chk_state({tag, "_sys"}, 3);
        repeat (3) tick();
        chk_state({tag, "_sys_end"}, 3);
        tick(); chk_state({tag, "_tx"}, 4);
        repeat (3) tick();
        chk_state({tag, "_tx_end"}, 4);
        tick(); chk_state({tag, "_rx"}, 5);
        tick(); chk_state({tag, "_run"}, 6);
    endtask

    // Entered HOLD on the last tick: 15 more ticks in HOLD, the 16th enters LOCK.
    task automatic hold_to_lock(input string tag);
        repeat (15) tick();
        chk_state({tag, "_hold_end"}, 1);
        tick();
        chk_state({tag, "_lock"}, 2);
    endtask

    initial begin
        int n;
        HRESETn      = 1'b0;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        err_clr      = 1'b0;

        repeat (3) @(posedge HCLK);
        #1;
        chk_state("reset", 0);
        check_val("reset_lock_err", 32'(lock_err), 32'd0);
        check_val("reset_clk_err", 32'(clk_err), 32'd0);
        HRESETn = 1'b1;
        run_from_reset();
        check_val("run_clk_err", 32'(clk_err), 32'd0);

        // Soft reset held 5 cycles in RUN
        soft_rst_req = 1'b1;
        tick(); chk_state("soft_first", 1);
        repeat (4) tick();
        chk_state("soft_held", 1);
        soft_rst_req = 1'b0;
        hold_to_lock("soft");
        release_seq("soft");

        // Loss of lock in RUN, then lock timeout while waiting
        pll_lock = 1'b0;
        repeat (2) tick();
        chk_state("lockdrop_wait", 6);
        tick(); chk_state("lockdrop_abort", 1);
        hold_to_lock("lockdrop");
        repeat (1023) tick();
        chk_state("lock_waiting", 2);
        check_val("lock_err_before", 32'(lock_err), 32'd0);
        tick(); chk_state("lock_timeout", 1);
        check_val("lock_err_set", 32'(lock_err), 32'd1);
        pll_lock = 1'b1;
        hold_to_lock("retry");
        release_seq("retry");
        check_val("lock_err_sticky", 32'(lock_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("lock_err_clr", 32'(lock_err), 32'd0);
        chk_state("after_clr", 6);

        // Abort beats the SYS->TX advance on the same edge
        soft_rst_req = 1'b1;
        tick(); chk_state("abort2", 1);
        soft_rst_req = 1'b0;
        hold_to_lock("abort2");
        tick(); chk_state("abort2_sys", 3);
        repeat (3) tick();
        chk_state("abort2_sys_end", 3);
        soft_rst_req = 1'b1;
        tick(); chk_state("abort_wins", 1);
        soft_rst_req = 1'b0;

        // Asynchronous reset in the middle of TX
        hold_to_lock("hrst");
        tick(); chk_state("hrst_sys", 3);
        repeat (5) tick();
        chk_state("hrst_tx", 4);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_state("hrst_async", 0);
        @(posedge HCLK);
        #1;
        chk_state("hrst_held", 0);
        HRESETn = 1'b1;
        run_from_reset();

`ifdef TSE_RSTSEQ_CLKMON_EN
        // Stop the TX line clock in RUN
        tx_run = 1'b0;
        n = 0;
        while (state_o == 3'd6 && n < 200) begin
            tick();
            n++;
        end
        check_val("clkmon_latency_ok", 32'(n >= 64 && n <= 70), 32'd1);
        chk_state("clkmon_abort", 1);
        check_val("clk_err_tx", 32'(clk_err), 32'd1);
        hold_to_lock("clkmon");
        repeat (40) tick();
        chk_state("clkmon_blocked", 2);
        tx_run = 1'b1;
        n = 0;
        while (state_o != 3'd6 && n < 40) begin
            tick();
            n++;
        end
        chk_state("clkmon_recover", 6);
        check_val("clk_err_sticky", 32'(clk_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("clk_err_clr", 32'(clk_err), 32'd0);
`else
        // Without the monitor, a stopped line clock changes nothing
        tx_run = 1'b0;
        rx_run = 1'b0;
        n = 0;
        repeat (100) tick();
        chk_state("noclkmon_run", 6);
        check_val("noclkmon_clk_err", 32'(clk_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
